// File: rtl/group_arr_piler.sv
// group_arr_piler: packs ArrL piled entries into one BABA group word behind a single-group output slot.
// Optional GROUP_ARR_PILER_FLUSH_EN adds in_last/out_cnt so a stream can end on a short, zero-padded group.
module group_arr_piler #(
    parameter int ArrL      = 32,
    parameter int Arr1EleW  = 8,
    parameter int Arr2EleW  = Arr1EleW,
    parameter int Arr3EleW  = Arr2EleW,
    parameter int Arr4EleW  = Arr3EleW,
    parameter int piledArrW = Arr1EleW + Arr2EleW + Arr3EleW + Arr4EleW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [piledArrW-1:0]      in_ele,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ArrL*piledArrW-1:0] out_groupArrBABA
`ifdef GROUP_ARR_PILER_FLUSH_EN
    ,
    input  logic                      in_last,
    output logic [$clog2(ArrL+1)-1:0] out_cnt
`endif
);
    localparam int IW = $clog2(ArrL);
    localparam int CW = $clog2(ArrL + 1);

    typedef enum logic {FILL, FULL_WAIT} state_t;

    state_t                         r_state, w_state_next;
    logic [ArrL-1:0][piledArrW-1:0] r_buf, w_merged, w_masked;
    logic [ArrL*piledArrW-1:0]      r_out;
    logic                           r_out_valid;
    logic [IW-1:0]                  r_idx;
    logic                           w_beat, w_last, w_slot_free;
    logic                           w_load_fill, w_load_wait, w_to_wait;

    assign in_ready         = !rst && r_state == FILL;
    assign w_beat           = in_valid && in_ready;
    assign w_slot_free      = !r_out_valid || out_ready;
    assign out_valid        = r_out_valid;
    assign out_groupArrBABA = r_out;

`ifdef GROUP_ARR_PILER_FLUSH_EN
    logic [CW-1:0] r_cnt;
    assign out_cnt = r_cnt;
    assign w_last  = r_idx == IW'(ArrL - 1) || in_last;
`else
    assign w_last  = r_idx == IW'(ArrL - 1);
`endif

    genvar k;
    for (k = 0; k < ArrL; k++) begin : g_ent
        assign w_merged[k] = (r_idx == IW'(k)) ? in_ele : r_buf[k];
`ifdef GROUP_ARR_PILER_FLUSH_EN
        // Stale entries from an earlier group must not leak into a short group.
        assign w_masked[k] = (IW'(k) <= r_idx) ? w_merged[k] : '0;
`else
        assign w_masked[k] = w_merged[k];
`endif
    end

    always_comb begin
        w_load_fill  = r_state == FILL && w_beat && w_last && w_slot_free;
        w_to_wait    = r_state == FILL && w_beat && w_last && !w_slot_free;
        w_load_wait  = r_state == FULL_WAIT && w_slot_free;
        w_state_next = w_to_wait ? FULL_WAIT : (w_load_wait ? FILL : r_state);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_state_next;
    end

    // In FULL_WAIT r_idx stays at the completing index, so the count is still derivable on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
`ifdef GROUP_ARR_PILER_FLUSH_EN
            r_cnt       <= '0;
`endif
        end else if (w_load_fill || w_load_wait) begin
            r_out       <= w_load_fill ? w_masked : r_buf;
            r_out_valid <= 1'b1;
            r_idx       <= '0;
`ifdef GROUP_ARR_PILER_FLUSH_EN
            r_cnt       <= CW'(r_idx) + CW'(1);
`endif
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (w_to_wait) r_buf <= w_masked;
            else if (w_beat) begin
                r_buf <= w_merged;
                r_idx <= r_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_group_arr_piler.sv
// tb_group_arr_piler: directed checks of group_arr_piler with ArrL=4 (32-bit and 16-bit entries).
// Covers GROUP_ARR_PILER_FLUSH_EN when that macro is defined for the build.
module tb_group_arr_piler;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [31:0]  in_ele;
    logic [127:0] group;
    logic         in_valid16, in_ready16, out_valid16;
    logic [15:0]  in_ele16;
    logic [63:0]  group16;
    int           passed = 0;
    int           total  = 0;
`ifdef GROUP_ARR_PILER_FLUSH_EN
    logic         in_last;
    logic [2:0]   out_cnt, out_cnt16;
`endif

    always #5 clk = ~clk;

    group_arr_piler #(.ArrL(4), .Arr1EleW(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ele(in_ele),
        .out_valid(out_valid), .out_ready(out_ready), .out_groupArrBABA(group)
`ifdef GROUP_ARR_PILER_FLUSH_EN
        , .in_last(in_last), .out_cnt(out_cnt)
`endif
    );

    group_arr_piler #(.ArrL(4), .Arr1EleW(8), .Arr3EleW(0), .Arr4EleW(0)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_ele(in_ele16),
        .out_valid(out_valid16), .out_ready(1'b1), .out_groupArrBABA(group16)
`ifdef GROUP_ARR_PILER_FLUSH_EN
        , .in_last(1'b0), .out_cnt(out_cnt16)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rep(input logic [7:0] b);
        return {4{b}};
    endfunction

    function automatic logic [127:0] grp(input logic [7:0] b0);
        return {rep(b0 + 8'd3), rep(b0 + 8'd2), rep(b0 + 8'd1), rep(b0)};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ele = '0; out_ready = 1'b1;
        in_valid16 = 1'b0; in_ele16 = '0;
`ifdef GROUP_ARR_PILER_FLUSH_EN
        in_last = 1'b0;
`endif
        #2;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_group", group, 128'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'd1);

        // single group of the reference vectors
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_ele = {8'(16 * i + 3), 8'(16 * i + 2), 8'(16 * i + 1), 8'(16 * i)};
            tick();
            check($sformatf("g1_valid_%0d", i), 128'(out_valid), 128'(i == 3));
            check($sformatf("g1_in_ready_%0d", i), 128'(in_ready), 128'd1);
        end
        check("g1_group", group, 128'h33323130_23222120_13121110_03020100);
`ifdef GROUP_ARR_PILER_FLUSH_EN
        check("g1_cnt", 128'(out_cnt), 128'd4);
`endif
        in_valid = 1'b0;
        tick();
        check("g1_drop", 128'(out_valid), 128'd0);

        // 12 back-to-back entries, no bubbles
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_ele = rep(8'(i + 1));
            tick();
            check($sformatf("s_valid_%0d", i), 128'(out_valid), 128'(i % 4 == 3));
            check($sformatf("s_in_ready_%0d", i), 128'(in_ready), 128'd1);
            if (i % 4 == 3) check($sformatf("s_group_%0d", i / 4), group, grp(8'(i - 2)));
        end
        in_valid = 1'b0;
        tick();
        check("s_drop", 128'(out_valid), 128'd0);

        // downstream stall: hold group 1 while group 2 fills
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_ele = rep(8'(8'h20 + i));
            tick();
            check($sformatf("st_valid_%0d", i), 128'(out_valid), 128'(i >= 3));
            check($sformatf("st_in_ready_%0d", i), 128'(in_ready), 128'(i != 7));
            if (i >= 3) check($sformatf("st_hold_%0d", i), group, grp(8'h20));
        end
        in_valid = 1'b0;
        tick();
        check("st_wait_in_ready", 128'(in_ready), 128'd0);
        check("st_wait_group", group, grp(8'h20));
        out_ready = 1'b1;
        tick();
        check("st_rel_valid", 128'(out_valid), 128'd1);
        check("st_rel_group", group, grp(8'h24));
        check("st_rel_in_ready", 128'(in_ready), 128'd1);
        tick();
        check("st_rel_drop", 128'(out_valid), 128'd0);

        // reset mid-group discards partial entries
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_ele = rep(8'hAA + 8'(i));
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mr_valid", 128'(out_valid), 128'd0);
        check("mr_in_ready", 128'(in_ready), 128'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mr_after_valid", 128'(out_valid), 128'd0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_ele = rep(8'(8'h40 + i));
            tick();
            check($sformatf("mr_valid_%0d", i), 128'(out_valid), 128'(i == 3));
        end
        check("mr_group", group, grp(8'h40));
        in_valid = 1'b0;

        // 16-bit entries pack without gaps
        for (int i = 0; i < 4; i++) begin
            in_valid16 = 1'b1;
            in_ele16 = {8'(8'h11 * (i + 1)), 8'(8'h11 * i)};
            tick();
            check($sformatf("n16_valid_%0d", i), 128'(out_valid16), 128'(i == 3));
        end
        check("n16_group", 128'(group16), 128'h4433_3322_2211_1100);
        in_valid16 = 1'b0;
        tick();
        check("n16_drop", 128'(out_valid16), 128'd0);

`ifdef GROUP_ARR_PILER_FLUSH_EN
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_last = (i == 2);
            in_ele = rep(8'(8'h51 + i));
            tick();
            check($sformatf("fl_valid_%0d", i), 128'(out_valid), 128'(i == 2));
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        check("fl_cnt", 128'(out_cnt), 128'd3);
        check("fl_group", group, {32'd0, rep(8'h53), rep(8'h52), rep(8'h51)});
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
